// File: rtl/sha3_digest_checker.sv
// ---------------------------------------------------------------------------
// sha3_digest_checker
//
// Purpose:
//   Sits downstream of the Keccak output stage and reassembles its MSB-first
//   byte stream into one parallel digest of DIGEST_BYTES bytes. The assembled
//   digest is compared against a reference value and the result is held until
//   it is acknowledged, back-pressuring the byte stream in the meantime.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   data_in       digest byte, first byte of a digest is the MSB
//   valid_in      data_in / end_in valid this cycle
//   end_in        last byte of a digest (only meaningful with valid_in)
//   ready_in      checker accepts a byte this cycle (COLLECT state)
//   expected      reference digest, sampled on the completing edge
//   res_ack       consume the held result and start the next collection
//   digest_out    assembled digest
//   digest_valid  digest_out / match / err_short valid and held (HOLD state)
//   match         assembled digest equals expected
//   err_short     digest ended before DIGEST_BYTES bytes arrived
//   digest_count  completed digests since reset, wraps silently
// ---------------------------------------------------------------------------
module sha3_digest_checker #(
   parameter int DIGEST_BYTES = 64,
   parameter int COUNT_W      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                data_in,
   input  logic                      valid_in,
   input  logic                      end_in,
   output logic                      ready_in,
   input  logic [8*DIGEST_BYTES-1:0] expected,
   input  logic                      res_ack,
   output logic [8*DIGEST_BYTES-1:0] digest_out,
   output logic                      digest_valid,
   output logic                      match,
   output logic                      err_short,
   output logic [COUNT_W-1:0]        digest_count
);

   localparam int             DW       = 8 * DIGEST_BYTES;
   localparam logic [5:0]     LAST_IDX = 6'(DIGEST_BYTES - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [5:0]           idx_q, idx_d;
   logic [DW-1:0]        digest_q, digest_d;
   logic                 match_q, match_d;
   logic                 err_short_q, err_short_d;
   logic [COUNT_W-1:0]   count_q, count_d;

   logic                 accept;
   logic [DW-1:0]        digest_wr;

   // Handshake flags depend on the state register alone, so they never
   // combinationally follow valid_in or res_ack.
   assign ready_in     = (state_q == COLLECT);
   assign digest_valid = (state_q == HOLD);
   assign accept       = valid_in & ready_in;

   // Digest with the incoming byte dropped into slot idx. Byte 0 lands in the
   // most significant position; slots not yet written keep their cleared value.
   // The compare on the completing edge uses this post-write value.
   always_comb begin
      digest_wr = digest_q;
      for (int k = 0; k < DIGEST_BYTES; k++) begin
         if (idx_q == 6'(k)) begin
            digest_wr[DW-8-8*k +: 8] = data_in;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      digest_d    = digest_q;
      match_d     = match_q;
      err_short_d = err_short_q;
      count_d     = count_q;

      case (state_q)
         COLLECT: begin
            if (accept) begin
               digest_d = digest_wr;
               if (idx_q == LAST_IDX) begin
                  // Full-length digest; end_in on this beat is optional.
                  idx_d       = 6'd0;
                  state_d     = HOLD;
                  err_short_d = 1'b0;
                  match_d     = (digest_wr == expected);
                  count_d     = count_q + COUNT_W'(1);
               end else if (end_in) begin
                  // Early end: the remaining bytes stay zero and never match.
                  idx_d       = 6'd0;
                  state_d     = HOLD;
                  err_short_d = 1'b1;
                  match_d     = 1'b0;
                  count_d     = count_q + COUNT_W'(1);
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         HOLD: begin
            // match / err_short stay put until the next digest completes.
            if (res_ack) begin
               state_d  = COLLECT;
               digest_d = '0;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= COLLECT;
         idx_q       <= 6'd0;
         digest_q    <= '0;
         match_q     <= 1'b0;
         err_short_q <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         digest_q    <= digest_d;
         match_q     <= match_d;
         err_short_q <= err_short_d;
         count_q     <= count_d;
      end
   end

   assign digest_out   = digest_q;
   assign match        = match_q;
   assign err_short    = err_short_q;
   assign digest_count = count_q;

endmodule

// File: tb/tb_sha3_digest_checker.sv
// ---------------------------------------------------------------------------
// tb_sha3_digest_checker
//
// Purpose:
//   Drives directed and random byte streams into sha3_digest_checker. A
//   reference model tracks the byte list of the digest in progress, the held
//   result and the digest counter; every completed digest is queued as an
//   expected result that a separate monitor pops when digest_valid rises.
//   The monitor also compares all outputs against the model every cycle.
//   COUNT_W is 2 so the counter wrap is exercised.
// ---------------------------------------------------------------------------
module tb_sha3_digest_checker;

   localparam int NB = 64;
   localparam int CW = 2;
   localparam int DW = 8 * NB;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [7:0]      data_in = 8'h00;
   logic            valid_in = 1'b0;
   logic            end_in = 1'b0;
   logic            ready_in;
   logic [DW-1:0]   expected = '0;
   logic            res_ack = 1'b0;
   logic [DW-1:0]   digest_out;
   logic            digest_valid;
   logic            match;
   logic            err_short;
   logic [CW-1:0]   digest_count;

   always #5 clk = ~clk;

   sha3_digest_checker #(
      .DIGEST_BYTES (NB),
      .COUNT_W      (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .valid_in     (valid_in),
      .end_in       (end_in),
      .ready_in     (ready_in),
      .expected     (expected),
      .res_ack      (res_ack),
      .digest_out   (digest_out),
      .digest_valid (digest_valid),
      .match        (match),
      .err_short    (err_short),
      .digest_count (digest_count)
   );

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [DW-1:0] digest;
      bit            match;
      bit            err;
      int            count;
   } result_t;

   result_t sb[$];

   // Reference model state
   bit            checking = 1'b0;
   bit            m_hold   = 1'b0;
   int            m_len    = 0;
   logic [DW-1:0] m_acc    = '0;
   logic [DW-1:0] m_held   = '0;
   bit            m_match  = 1'b0;
   bit            m_err    = 1'b0;
   int            m_count  = 0;

   task automatic checkOutput(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Behavioural model: a digest is the list of accepted bytes placed MSB
   // first; it closes after NB bytes or on an end-flagged byte.
   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            checking = 1'b1;
            m_hold   = 1'b0;
            m_len    = 0;
            m_acc    = '0;
            m_held   = '0;
            m_match  = 1'b0;
            m_err    = 1'b0;
            m_count  = 0;
         end else if (m_hold) begin
            if (res_ack) m_hold = 1'b0;
         end else if (valid_in) begin
            m_acc[DW-1-8*m_len -: 8] = data_in;
            m_len++;
            if (m_len == NB || end_in) begin
               m_err   = (m_len < NB);
               m_match = !m_err && (m_acc == expected);
               m_count = (m_count + 1) % (1 << CW);
               m_held  = m_acc;
               m_hold  = 1'b1;
               sb.push_back('{m_acc, m_match, m_err, m_count});
               m_len   = 0;
               m_acc   = '0;
            end
         end
      end
   end

   // Monitor: per-cycle output checks plus scoreboard pop on each new result.
   initial begin
      bit      prev_valid;
      result_t r;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (checking) begin
            checkOutput("ready_in",     DW'(ready_in),     DW'(!m_hold));
            checkOutput("digest_valid", DW'(digest_valid), DW'(m_hold));
            checkOutput("digest_count", DW'(digest_count), DW'(m_count));
            checkOutput("match",        DW'(match),        DW'(m_match));
            checkOutput("err_short",    DW'(err_short),    DW'(m_err));
            checkOutput("digest_out",   digest_out,        m_hold ? m_held : m_acc);
            if (digest_valid === 1'b1 && !prev_valid) begin
               if (sb.size() == 0) begin
                  checks++;
                  fails++;
                  $display("[TB] FAIL sb_pending: got 0 queued results, required 1");
               end else begin
                  r = sb.pop_front();
                  checkOutput("sb_digest", digest_out,        r.digest);
                  checkOutput("sb_match",  DW'(match),        DW'(r.match));
                  checkOutput("sb_err",    DW'(err_short),    DW'(r.err));
                  checkOutput("sb_count",  DW'(digest_count), DW'(r.count));
               end
            end
            prev_valid = (digest_valid === 1'b1);
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no end of test, required finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e,
                                input logic a);
      @(negedge clk);
      valid_in = v;
      data_in  = d;
      end_in   = e;
      res_ack  = a;
   endtask

   // Offers one byte until accepted. While the result is held, res_ack is
   // raised after ackDelay refused cycles, with valid_in still asserted.
   task automatic pushByte(input logic [7:0] d, input logic e, input int ackDelay);
      int w;
      w = 0;
      if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 8'($urandom), 1'($urandom), 1'b0);
      while (1) begin
         applyStimulus(1'b1, d, e, (w >= ackDelay) ? 1'b1 : 1'b0);
         if (ready_in === 1'b1) break;
         w++;
         if (w > 500) begin
            checks++;
            fails++;
            $display("[TB] FAIL ready_timeout: got ready_in=%b, required 1 within 500 cycles", ready_in);
            break;
         end
      end
   endtask

   task automatic sendDigest(input logic [DW-1:0] d, input int len, input bit endLast,
                             input int ackDelay);
      for (int k = 0; k < len; k++) begin
         pushByte(d[DW-1-8*k -: 8], (k == len - 1) && endLast, (k == 0) ? ackDelay : 0);
      end
   endtask

   task automatic doReset(input int n);
      @(negedge clk);
      reset    = 1'b1;
      valid_in = 1'b0;
      res_ack  = 1'b0;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [DW-1:0] randDigest();
      logic [DW-1:0] d;
      for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = $urandom;
      return d;
   endfunction

   initial begin
      logic [DW-1:0] pat;
      logic [DW-1:0] padded;
      logic [DW-1:0] aa;
      int            len;
      bit            endLast;

      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Ascending pattern, matching expected
      for (int k = 0; k < NB; k++) pat[DW-1-8*k -: 8] = 8'(k);
      expected = pat;
      sendDigest(pat, NB, 1'b1, 0);
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      // Same stream, byte 17 of expected flipped
      expected = pat;
      expected[DW-1-8*17 -: 8] = ~pat[DW-1-8*17 -: 8];
      sendDigest(pat, NB, 1'b1, 2);

      // Short digest of ten 0xAA bytes; expected equals the zero-padded value
      aa = '0;
      for (int k = 0; k < 10; k++) aa[DW-1-8*k -: 8] = 8'hAA;
      expected = aa;
      sendDigest(aa, 10, 1'b1, 0);

      // Byte offered for 20 held cycles before the acknowledge, no end flag
      pat = randDigest();
      expected = pat;
      sendDigest(pat, NB, 1'b0, 20);

      // Reset after 30 bytes, then a fresh matching digest
      sendDigest(randDigest(), 30, 1'b0, 1);
      doReset(2);
      pat = randDigest();
      expected = pat;
      sendDigest(pat, NB, 1'b1, 0);

      // Boundary lengths
      pat = randDigest();
      sendDigest(pat, NB - 1, 1'b1, 1);
      sendDigest(pat, 1, 1'b1, 0);

      // Random digests; counter wraps repeatedly with COUNT_W = 2
      for (int n = 0; n < 40; n++) begin
         len     = $urandom_range(1, NB);
         endLast = (len < NB) ? 1'b1 : 1'($urandom);
         pat     = randDigest();
         padded  = '0;
         for (int k = 0; k < len; k++) padded[DW-1-8*k -: 8] = pat[DW-1-8*k -: 8];
         case ($urandom_range(0, 2))
            0:       expected = padded;
            1: begin
               expected = padded;
               expected[DW-1-8*$urandom_range(0, NB-1) -: 8] ^= 8'h01;
            end
            default: expected = randDigest();
         endcase
         sendDigest(pat, len, endLast, $urandom_range(0, 5));
      end

      // Release the final result and let the pipeline settle
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      checkOutput("sb_drained", DW'(sb.size()), DW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
